// File: rtl/md_ctrl_e.sv
// md_ctrl_e: execute-stage multiply/divide sequencer that owns the HI/LO registers.
// A mult or div op is computed when it is launched and held internally. busy stays
// high for a fixed latency, and the held result lands in HI/LO on the final busy edge.
// mthi/mtlo write HI or LO directly in one cycle.
// Build option: define MD_MADD_EN to enable the madd/maddu/msub/msubu accumulate ops (7..10).
module md_ctrl_e #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  // state | meaning
  // IDLE  | accepting md ops; mthi/mtlo write immediately
  // RUN   | mult/div in flight; counter runs down to the write edge
  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 1);

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic [63:0] res;
  logic        res_wr;
  logic        is_mul, is_div, op_signed;
  logic        launch, finish, mt_hi, mt_lo;
  logic [63:0] ext_rs, ext_rt, prod, mul_res;
  logic [31:0] abs_rs, abs_rt, quo, rem, div_hi, div_lo;
`ifdef MD_MADD_EN
  logic        is_acc, is_sub;
`endif

  // Decode the op into unit select and signedness
  always_comb begin
    is_mul    = 1'b0;
    is_div    = 1'b0;
    op_signed = 1'b0;
`ifdef MD_MADD_EN
    is_acc    = 1'b0;
    is_sub    = 1'b0;
`endif
    case (md_op)
      4'd1: begin is_mul = 1'b1; op_signed = 1'b1; end
      4'd2: is_mul = 1'b1;
      4'd3: begin is_div = 1'b1; op_signed = 1'b1; end
      4'd4: is_div = 1'b1;
`ifdef MD_MADD_EN
      4'd7:  begin is_mul = 1'b1; is_acc = 1'b1; op_signed = 1'b1; end
      4'd8:  begin is_mul = 1'b1; is_acc = 1'b1; end
      4'd9:  begin is_mul = 1'b1; is_acc = 1'b1; is_sub = 1'b1; op_signed = 1'b1; end
      4'd10: begin is_mul = 1'b1; is_acc = 1'b1; is_sub = 1'b1; end
`endif
      default: ;
    endcase
  end

  assign launch = start && (state == IDLE) && (is_mul || is_div);
  assign finish = (state == RUN) && (cnt == 4'd0);
  assign mt_hi  = start && (state == IDLE) && (md_op == 4'd5);
  assign mt_lo  = start && (state == IDLE) && (md_op == 4'd6);

  // Extending to 64 bits and keeping the low 64 bits of the product gives both signed and unsigned results
  assign ext_rs = op_signed ? {{32{rs_val[31]}}, rs_val} : {32'b0, rs_val};
  assign ext_rt = op_signed ? {{32{rt_val[31]}}, rt_val} : {32'b0, rt_val};
  assign prod   = ext_rs * ext_rt;
`ifdef MD_MADD_EN
  assign mul_res = !is_acc ? prod : (is_sub ? ({hi, lo} - prod) : ({hi, lo} + prod));
`else
  assign mul_res = prod;
`endif

  // Sign-magnitude divide; 0x80000000 / -1 wraps naturally to 0x80000000
  assign abs_rs = (op_signed && rs_val[31]) ? -rs_val : rs_val;
  assign abs_rt = (op_signed && rt_val[31]) ? -rt_val : rt_val;
  assign quo    = (rt_val == 32'd0) ? 32'd0 : abs_rs / abs_rt;
  assign rem    = (rt_val == 32'd0) ? 32'd0 : abs_rs % abs_rt;
  assign div_lo = (op_signed && (rs_val[31] ^ rt_val[31])) ? -quo : quo;
  assign div_hi = (op_signed && rs_val[31]) ? -rem : rem;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and busy
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    case (state)
      IDLE: if (launch) state_nxt = RUN;
      RUN: begin
        busy = 1'b1;
        if (cnt == 4'd0) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Latency counter, held result, done pulse and HI/LO writes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= 4'd0;
      res    <= 64'd0;
      res_wr <= 1'b0;
      done   <= 1'b0;
      hi     <= 32'd0;
      lo     <= 32'd0;
    end else begin
      done <= finish;
      if (launch) begin
        cnt    <= is_div ? DIV_LOAD : MULT_LOAD;
        res    <= is_div ? {div_hi, div_lo} : mul_res;
        res_wr <= !(is_div && (rt_val == 32'd0));
      end else if ((state == RUN) && (cnt != 4'd0)) begin
        cnt <= cnt - 4'd1;
      end
      if (finish && res_wr) begin
        hi <= res[63:32];
        lo <= res[31:0];
      end else if (mt_hi) begin
        hi <= rs_val;
      end else if (mt_lo) begin
        lo <= rs_val;
      end
    end
  end
endmodule
